// File: rtl/pr_kernel_op_if.sv
// Pixel-side bundle between the window/line-buffer, the kernel operator and the VGA output mux.
// The master drives the window, the counters and the mode request; the slave returns colour and mode status.
interface pr_kernel_op_if #(
    parameter int PIX_W = 8,
    parameter int OUT_W = 4,
    parameter int H_W   = 10
);
    logic                 blank;
    logic [H_W-1:0]       hc;
    logic [H_W-1:0]       vc;
    logic [12*PIX_W-1:0]  dout;
    logic [2:0]           mode_req;
    logic                 mode_load;
    logic [PIX_W-1:0]     thresh;
    logic [OUT_W-1:0]     redx;
    logic [OUT_W-1:0]     greenx;
    logic [OUT_W-1:0]     bluex;
    logic [2:0]           mode_active;
    logic                 mode_pending;

    modport master (
        output blank, hc, vc, dout, mode_req, mode_load, thresh,
        input  redx, greenx, bluex, mode_active, mode_pending
    );

    modport slave (
        input  blank, hc, vc, dout, mode_req, mode_load, thresh,
        output redx, greenx, bluex, mode_active, mode_pending
    );
endinterface

// File: rtl/pr_kernel_op.sv
// Three-stage 3x3 neighbourhood operator with eight frame-synchronous modes
// (bypass, gray, edge, binary edge, inverted edge, blur, two reserved).
module pr_kernel_op #(
    parameter int PIX_W = 8,
    parameter int OUT_W = 4,
    parameter int H_W   = 10,
    parameter int X0    = 100,
    parameter int X1    = 260,
    parameter int Y0    = 100,
    parameter int Y1    = 215
) (
    input logic         pixel_clk,
    input logic         reset,
    pr_kernel_op_if.slave bus
);
    localparam int LW = PIX_W + 4;
    localparam int SW = PIX_W + 3;
    localparam int SH = PIX_W - OUT_W;
    localparam logic [H_W-1:0]   X0_C = H_W'(X0);
    localparam logic [H_W-1:0]   X1_C = H_W'(X1);
    localparam logic [H_W-1:0]   Y0_C = H_W'(Y0);
    localparam logic [H_W-1:0]   Y1_C = H_W'(Y1);
    localparam logic [PIX_W-1:0] MAX  = {PIX_W{1'b1}};

    logic in_win;
    logic fs;

    assign in_win = !bus.blank && (bus.hc >= X0_C) && (bus.hc < X1_C)
                    && (bus.vc >= Y0_C) && (bus.vc < Y1_C);
    assign fs     = (bus.hc == '0) && (bus.vc == '0);

    // A load coincident with frame start bypasses the pending slot.
    logic [2:0] mode_act;
    logic [2:0] pend_mode;
    logic       pending;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            mode_act  <= 3'd2;
            pend_mode <= 3'd0;
            pending   <= 1'b0;
        end else if (fs && bus.mode_load) begin
            mode_act  <= bus.mode_req;
            pending   <= 1'b0;
        end else if (fs && pending) begin
            mode_act  <= pend_mode;
            pending   <= 1'b0;
        end else if (bus.mode_load) begin
            pend_mode <= bus.mode_req;
            pending   <= 1'b1;
        end
    end

    // Field k sits at dout[k*PIX_W +: PIX_W]: 0 red, 1 green, 2 blue, 3..10 neighbours, 11 centre.
    logic [PIX_W-1:0] s1_f [12];
    logic             s1_win;
    logic [PIX_W-1:0] s1_thr;
    logic [2:0]       s1_mode;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            for (int k = 0; k < 12; k++) s1_f[k] <= '0;
            s1_win  <= 1'b0;
            s1_thr  <= '0;
            s1_mode <= 3'd0;
        end else begin
            for (int k = 0; k < 12; k++) s1_f[k] <= bus.dout[k*PIX_W +: PIX_W];
            s1_win  <= in_win;
            s1_thr  <= bus.thresh;
            s1_mode <= mode_act;
        end
    end

    logic [SW-1:0]        nsum_c;
    logic signed [LW-1:0] lap_c;

    always_comb begin
        nsum_c = '0;
        for (int k = 3; k < 11; k++) nsum_c = nsum_c + SW'(s1_f[k]);
        lap_c = $signed(LW'({s1_f[11], 3'b000})) - $signed(LW'(nsum_c));
    end

    logic signed [LW-1:0] s2_lap;
    logic [PIX_W-1:0]     s2_blur;
    logic [PIX_W-1:0]     s2_c;
    logic [PIX_W-1:0]     s2_r;
    logic [PIX_W-1:0]     s2_g;
    logic [PIX_W-1:0]     s2_b;
    logic                 s2_win;
    logic [PIX_W-1:0]     s2_thr;
    logic [2:0]           s2_mode;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            s2_lap  <= '0;
            s2_blur <= '0;
            s2_c    <= '0;
            s2_r    <= '0;
            s2_g    <= '0;
            s2_b    <= '0;
            s2_win  <= 1'b0;
            s2_thr  <= '0;
            s2_mode <= 3'd0;
        end else begin
            s2_lap  <= lap_c;
            s2_blur <= nsum_c[SW-1:3];
            s2_c    <= s1_f[11];
            s2_r    <= s1_f[0];
            s2_g    <= s1_f[1];
            s2_b    <= s1_f[2];
            s2_win  <= s1_win;
            s2_thr  <= s1_thr;
            s2_mode <= s1_mode;
        end
    end

    logic [PIX_W-1:0] clp;
    logic [PIX_W-1:0] v_r;
    logic [PIX_W-1:0] v_g;
    logic [PIX_W-1:0] v_b;

    always_comb begin
        if (s2_lap[LW-1])
            clp = '0;
        else if (|s2_lap[LW-2:PIX_W])
            clp = MAX;
        else
            clp = s2_lap[PIX_W-1:0];
        v_r = '0;
        v_g = '0;
        v_b = '0;
        if (s2_win) begin
            case (s2_mode)
                3'd0: begin v_r = s2_r; v_g = s2_g; v_b = s2_b; end
                3'd1: begin v_r = s2_c; v_g = s2_c; v_b = s2_c; end
                3'd2: begin v_r = clp;  v_g = clp;  v_b = clp;  end
                3'd3: begin
                    v_r = (clp >= s2_thr) ? MAX : {PIX_W{1'b0}};
                    v_g = v_r;
                    v_b = v_r;
                end
                3'd4: begin v_r = MAX - clp; v_g = v_r; v_b = v_r; end
                3'd5: begin v_r = s2_blur; v_g = s2_blur; v_b = s2_blur; end
                default: ;
            endcase
        end
    end

    logic [OUT_W-1:0] red_q;
    logic [OUT_W-1:0] green_q;
    logic [OUT_W-1:0] blue_q;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            red_q   <= OUT_W'(v_r >> SH);
            green_q <= OUT_W'(v_g >> SH);
            blue_q  <= OUT_W'(v_b >> SH);
        end
    end

    assign bus.redx         = red_q;
    assign bus.greenx       = green_q;
    assign bus.bluex        = blue_q;
    assign bus.mode_active  = mode_act;
    assign bus.mode_pending = pending;
endmodule
